// File: rtl/ts_spy_pkg.sv
// Shared types and constants for the trigger-scintillator link spy buffer.
// A capture word is {err[1:0], k[1:0], d[15:0]}; the slice macro picks channel c of a packed bus.
`define TS_SPY_SLICE(c, w) ((c) * (w)) +: (w)

package ts_spy_pkg;

  localparam int unsigned TS_WORD_W = 20;

  typedef enum logic [1:0] {
    TS_SPY_IMM = 2'd0,
    TS_SPY_SW  = 2'd1,
    TS_SPY_PAT = 2'd2,
    TS_SPY_ERR = 2'd3
  } ts_spy_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } ts_spy_state_e;

  function automatic logic [TS_WORD_W-1:0] ts_spy_word(input logic [1:0]  err,
                                                       input logic [1:0]  k,
                                                       input logic [15:0] d);
    return {err, k, d};
  endfunction

endpackage

// File: rtl/ts_spy_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read of the address being written in the same cycle returns the old contents.
module ts_spy_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned W  = 20
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ts_spy_mc.sv
// Multi-channel triggered spy buffer: one circular capture RAM per link channel,
// frozen a programmable number of words after an immediate/software/pattern/error trigger.
module ts_spy_mc
  import ts_spy_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 6
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic [16*NCH-1:0]    rx_d,
  input  logic [2*NCH-1:0]     rx_k,
  input  logic [2*NCH-1:0]     rx_err,
  input  logic                 arm,
  input  logic [1:0]           mode,
  input  logic                 sw_trig,
  input  logic [3:0]           trig_ch,
  input  logic [17:0]          trig_pat,
  input  logic [17:0]          trig_mask,
  input  logic [AW-1:0]        post_count,
  input  logic [3:0]           rd_ch,
  input  logic [AW-1:0]        rd_addr,
  output logic [TS_WORD_W-1:0] rd_data,
  output logic [1:0]           state,
  output logic [AW-1:0]        trig_ptr,
  output logic                 wrapped
);

  localparam logic [4:0] NCH_L = 5'(NCH);

  ts_spy_state_e        state_q;
  ts_spy_mode_e         mode_q;
  logic [3:0]           tch_q;
  logic                 tch_ok_q;
  logic [AW-1:0]        post_q;
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        wptr_d;
  logic [AW-1:0]        cnt_q;
  logic [AW-1:0]        trig_ptr_q;
  logic                 wrapped_q;
  logic [3:0]           rd_ch_q;
  logic                 rd_ok_q;
  logic                 trig_hit;
  logic                 we;
  logic [TS_WORD_W-1:0] tw;
  logic [TS_WORD_W-1:0] ch_word [16];
  logic [TS_WORD_W-1:0] ram_rd  [16];

  // Per-channel arrays are padded to 16 entries so the 4-bit selects index them directly.
  for (genvar c = 0; c < 16; c++) begin : g_ch
    if (c < NCH) begin : g_on
      assign ch_word[c] = ts_spy_word(rx_err[`TS_SPY_SLICE(c, 2)],
                                      rx_k[`TS_SPY_SLICE(c, 2)],
                                      rx_d[`TS_SPY_SLICE(c, 16)]);
      ts_spy_ram #(
        .AW (AW),
        .W  (TS_WORD_W)
      ) u_ram (
        .clk_i   (rx_clk),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (ch_word[c]),
        .raddr_i (rd_addr),
        .rdata_o (ram_rd[c])
      );
    end else begin : g_off
      assign ch_word[c] = '0;
      assign ram_rd[c]  = '0;
    end
  end

  assign tw     = ch_word[tch_q];
  assign wptr_d = wptr_q + AW'(1);
  assign we     = rst_n && !arm && (state_q == ST_PRE || state_q == ST_POST);

  always_comb begin
    trig_hit = 1'b0;
    unique case (mode_q)
      TS_SPY_IMM: trig_hit = 1'b1;
      TS_SPY_SW:  trig_hit = sw_trig;
      TS_SPY_PAT: trig_hit = tch_ok_q && (((tw[17:0] ^ trig_pat) & trig_mask) == '0);
      TS_SPY_ERR: trig_hit = tch_ok_q && (|tw[19:18]);
      default:    trig_hit = 1'b0;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= TS_SPY_IMM;
      tch_q      <= '0;
      tch_ok_q   <= 1'b0;
      post_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
      wrapped_q  <= 1'b0;
    end else if (arm) begin
      state_q   <= ST_PRE;
      mode_q    <= ts_spy_mode_e'(mode);
      tch_q     <= trig_ch;
      tch_ok_q  <= ({1'b0, trig_ch} < NCH_L);
      post_q    <= post_count;
      wptr_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_PRE: begin
          wptr_q <= wptr_d;
          if (trig_hit) begin
            trig_ptr_q <= wptr_q;
            // Immediate mode fills the whole ring once, starting at address 0.
            if (mode_q == TS_SPY_IMM) begin
              cnt_q   <= '1;
              state_q <= ST_POST;
            end else begin
              cnt_q   <= post_q;
              state_q <= (post_q != '0) ? ST_POST : ST_DONE;
            end
          end else if (wptr_q == '1) begin
            wrapped_q <= 1'b1;
          end
        end
        ST_POST: begin
          wptr_q <= wptr_d;
          cnt_q  <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_q <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // RAMs register the read; the channel select is registered alongside to keep 1-cycle latency.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      rd_ch_q <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      rd_ch_q <= rd_ch;
      rd_ok_q <= ({1'b0, rd_ch} < NCH_L);
    end
  end

  assign rd_data  = rd_ok_q ? ram_rd[rd_ch_q] : '0;
  assign state    = state_q;
  assign trig_ptr = trig_ptr_q;
  assign wrapped  = wrapped_q;

endmodule
